// File: rtl/sha_mem_responder.sv
// ---------------------------------------------------------------------------
// sha_mem_responder
//
// Word-addressed memory that answers the SHA-256 engine's memory master port
// and also gives a host (CPU or bench) a port to preload message words and
// read results. Engine writes that land inside the digest window
// [out_base, out_base + DIGEST_WORDS) are also captured into a digest
// register, and digest_valid is raised once every word has been captured.
//
// Ports
//   clk                 clock (shared with the engine's mem_clk)
//   reset_n             asynchronous active-low reset
//   eng_sel_i           1 = engine owns the write port, 0 = host owns it
//   mem_we_i            engine write enable
//   mem_addr_i          engine word address
//   mem_write_data_i    engine write data
//   mem_read_data_o     engine read data, one cycle after the address
//   host_req_i          host request, held until host_ack_o
//   host_we_i           host write (1) / read (0), qualified by host_req_i
//   host_addr_i         host word address
//   host_wdata_i        host write data
//   host_rdata_o        host read data, valid while host_ack_o = 1
//   host_ack_o          one-cycle completion pulse
//   out_base_i          first word address of the digest window
//   digest_clr_i        clears digest_valid_o and the capture mask
//   digest_o            captured digest, word k at [32*(N-k)-1 -: 32]
//   digest_valid_o      all digest words captured since the last clear
//   addr_err_o          sticky out-of-range access flag
//   host_state_o        debug view of the host FSM (1 = H_ACK)
//
// Host handshake: the host raises host_req_i with host_we_i / host_addr_i /
// host_wdata_i stable and keeps them stable until it sees host_ack_o. The
// request is taken at the first clock edge where the FSM is idle and the
// engine does not own the port (eng_sel_i = 0); the access completes at that
// same edge and host_ack_o is high for exactly the following cycle, with
// host_rdata_o valid for reads. A request still held during the ack cycle is
// ignored; one still held after it starts a new transaction.
// ---------------------------------------------------------------------------
module sha_mem_responder #(
  parameter int DEPTH        = 256,
  parameter int DIGEST_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         eng_sel_i,
  input  logic                         mem_we_i,
  input  logic [15:0]                  mem_addr_i,
  input  logic [31:0]                  mem_write_data_i,
  output logic [31:0]                  mem_read_data_o,
  input  logic                         host_req_i,
  input  logic                         host_we_i,
  input  logic [15:0]                  host_addr_i,
  input  logic [31:0]                  host_wdata_i,
  output logic [31:0]                  host_rdata_o,
  output logic                         host_ack_o,
  input  logic [15:0]                  out_base_i,
  input  logic                         digest_clr_i,
  output logic [32*DIGEST_WORDS-1:0]   digest_o,
  output logic                         digest_valid_o,
  output logic                         addr_err_o,
  output logic                         host_state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;

  // 17-bit so that address + window arithmetic never wraps at 0xFFFF.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [16:0] DW_L    = 17'(DIGEST_WORDS);

  typedef enum logic {
    H_IDLE = 1'b0,
    H_ACK  = 1'b1
  } host_state_e;

  // -------------------------------------------------------------------------
  // Storage (contents are deliberately not reset)
  // -------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH];

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  host_state_e             state_q, state_d;
  logic [31:0]             mem_read_data_q;
  logic [31:0]             host_rdata_q;
  logic [31:0]             dword_q [DIGEST_WORDS];
  logic [DIGEST_WORDS-1:0] mask_q, mask_d;
  logic                    valid_q, valid_d;
  logic                    addr_err_q, addr_err_d;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic          eng_in_range;
  logic          host_in_range;
  logic          eng_wr_req;
  logic          eng_wr_ok;
  logic          host_go;
  logic          host_wr_ok;
  logic          host_rd;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [16:0]   win_off;
  logic          win_hit;
  logic [KW-1:0] win_idx;

  always_comb begin
    eng_in_range  = ({1'b0, mem_addr_i}  < DEPTH_L);
    host_in_range = ({1'b0, host_addr_i} < DEPTH_L);
    eng_wr_req    = eng_sel_i & mem_we_i;
    eng_wr_ok     = eng_wr_req & eng_in_range;
  end

  // -------------------------------------------------------------------------
  // Host FSM: next state and the "take the request now" strobe
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    host_go = 1'b0;
    case (state_q)
      H_IDLE: begin
        // The engine has priority; a pending host request just waits.
        if (host_req_i && !eng_sel_i) begin
          host_go = 1'b1;
          state_d = H_ACK;
        end
      end
      H_ACK: begin
        // The access already completed; eng_sel_i cannot cancel the ack.
        state_d = H_IDLE;
      end
      default: begin
        state_d = H_IDLE;
      end
    endcase
  end

  always_comb begin
    host_wr_ok = host_go & host_we_i & host_in_range;
    host_rd    = host_go & ~host_we_i;
  end

  // -------------------------------------------------------------------------
  // Single write port. Engine and host writes are mutually exclusive
  // because one needs eng_sel_i = 1 and the other eng_sel_i = 0.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_en   = eng_wr_ok | host_wr_ok;
    wr_addr = eng_sel_i ? mem_addr_i[AW-1:0] : host_addr_i[AW-1:0];
    wr_data = eng_sel_i ? mem_write_data_i   : host_wdata_i;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Digest window decode. The lower-bound test is done before using the
  // difference, so a window that runs past 0xFFFF only matches its
  // in-range part instead of wrapping to low addresses.
  // -------------------------------------------------------------------------
  always_comb begin
    win_off = {1'b0, mem_addr_i} - {1'b0, out_base_i};
    win_hit = eng_wr_ok && (mem_addr_i >= out_base_i) && (win_off < DW_L);
    win_idx = win_off[KW-1:0];
  end

  // Capture mask and valid. Clear beats a same-cycle capture for both; the
  // data register still takes the write (see below), it just is not flagged.
  always_comb begin
    mask_d = mask_q;
    if (win_hit) begin
      mask_d[win_idx] = 1'b1;
    end
    if (digest_clr_i) begin
      mask_d = '0;
    end
    valid_d = digest_clr_i ? 1'b0 : (valid_q | (&mask_d));
  end

  // Sticky error: any engine address out of range (reads happen every
  // cycle, so this also covers dropped engine writes) or an accepted host
  // access out of range.
  always_comb begin
    addr_err_d = addr_err_q | ~eng_in_range | (host_go & ~host_in_range);
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= H_IDLE;
      mem_read_data_q <= '0;
      host_rdata_q    <= '0;
      mask_q          <= '0;
      valid_q         <= 1'b0;
      addr_err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      valid_q    <= valid_d;
      addr_err_q <= addr_err_d;
      // Non-blocking read of the array gives old data on read-during-write.
      mem_read_data_q <= eng_in_range ? mem_q[mem_addr_i[AW-1:0]] : 32'h0;
      if (host_rd) begin
        host_rdata_q <= host_in_range ? mem_q[host_addr_i[AW-1:0]] : 32'h0;
      end
    end
  end

  // Digest data is only zeroed by reset, never by digest_clr_i.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DIGEST_WORDS; k++) begin
        dword_q[k] <= '0;
      end
    end else if (win_hit) begin
      dword_q[win_idx] <= mem_write_data_i;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    digest_o = '0;
    for (int k = 0; k < DIGEST_WORDS; k++) begin
      digest_o[32*(DIGEST_WORDS-k)-1 -: 32] = dword_q[k];
    end
  end

  assign mem_read_data_o = mem_read_data_q;
  assign host_rdata_o    = host_rdata_q;
  assign host_ack_o      = (state_q == H_ACK);
  assign digest_valid_o  = valid_q;
  assign addr_err_o      = addr_err_q;
  assign host_state_o    = (state_q == H_ACK);

endmodule

// File: tb/tb_sha_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_sha_mem_responder
//
// Directed sequence with randomized data/addresses, checked against a
// word-array model of the memory and digest window kept in this file.
// ---------------------------------------------------------------------------
module tb_sha_mem_responder;

  localparam int DEPTH = 256;
  localparam int DW    = 8;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset_n;
  logic          eng_sel;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;
  logic          host_req;
  logic          host_we;
  logic [15:0]   host_addr;
  logic [31:0]   host_wdata;
  logic [31:0]   host_rdata;
  logic          host_ack;
  logic [15:0]   out_base;
  logic          digest_clr;
  logic [255:0]  digest;
  logic          digest_valid;
  logic          addr_err;
  logic          host_state;

  always #5 clk = ~clk;

  sha_mem_responder #(.DEPTH(DEPTH), .DIGEST_WORDS(DW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .eng_sel_i        (eng_sel),
    .mem_we_i         (mem_we),
    .mem_addr_i       (mem_addr),
    .mem_write_data_i (mem_write_data),
    .mem_read_data_o  (mem_read_data),
    .host_req_i       (host_req),
    .host_we_i        (host_we),
    .host_addr_i      (host_addr),
    .host_wdata_i     (host_wdata),
    .host_rdata_o     (host_rdata),
    .host_ack_o       (host_ack),
    .out_base_i       (out_base),
    .digest_clr_i     (digest_clr),
    .digest_o         (digest),
    .digest_valid_o   (digest_valid),
    .addr_err_o       (addr_err),
    .host_state_o     (host_state)
  );

  // -------------------------------------------------------------------------
  // Counters and check helpers
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: plain word arrays and flags
  // -------------------------------------------------------------------------
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_dig [DW];
  bit          ref_mask [DW];
  bit          ref_valid;
  bit          ref_err;
  int          ref_base;

  function automatic void m_reset();
    for (int k = 0; k < DW; k++) begin
      ref_dig[k]  = 32'h0;
      ref_mask[k] = 1'b0;
    end
    ref_valid = 1'b0;
    ref_err   = 1'b0;
  endfunction

  function automatic logic [255:0] m_digest();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < DW; k++) begin
      r = {r[223:0], ref_dig[k]};
    end
    return r;
  endfunction

  function automatic bit m_all();
    for (int k = 0; k < DW; k++) begin
      if (!ref_mask[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Effect of one clock edge on the engine side.
  function automatic void m_eng_edge(input bit sel, input bit we, input int addr,
                                     input logic [31:0] d, input bit clr);
    if (addr >= DEPTH) ref_err = 1'b1;
    if (sel && we && addr < DEPTH) begin
      ref_mem[addr] = d;
      if (addr >= ref_base && addr < ref_base + DW) begin
        ref_dig[addr - ref_base]  = d;
        ref_mask[addr - ref_base] = 1'b1;
      end
    end
    if (clr) begin
      for (int k = 0; k < DW; k++) ref_mask[k] = 1'b0;
      ref_valid = 1'b0;
    end else if (m_all()) begin
      ref_valid = 1'b1;
    end
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic eng_cycle(input bit sel, input bit we, input int addr,
                           input logic [31:0] d, input bit clr);
    logic [31:0] exp_rd;
    @(negedge clk);
    eng_sel        = sel;
    mem_we         = we;
    mem_addr       = 16'(addr);
    mem_write_data = d;
    digest_clr     = clr;
    exp_rd = (addr < DEPTH) ? ref_mem[addr] : 32'h0;
    m_eng_edge(sel, we, addr, d, clr);
    @(posedge clk); #1;
    chk32("eng_rdata", mem_read_data, exp_rd);
    chk1("digest_valid", digest_valid, ref_valid);
    chk1("addr_err", addr_err, ref_err);
    chk256("digest", digest, m_digest());
  endtask

  task automatic set_base(input int b);
    @(negedge clk);
    eng_sel    = 1'b0;
    mem_we     = 1'b0;
    digest_clr = 1'b0;
    out_base   = 16'(b);
    ref_base   = b;
  endtask

  task automatic host_xact(input bit we, input int addr, input logic [31:0] wd);
    logic [31:0] exp_rd;
    int n;
    @(negedge clk);
    eng_sel    = 1'b0;
    mem_we     = 1'b0;
    digest_clr = 1'b0;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = 16'(addr);
    host_wdata = wd;
    exp_rd = (addr < DEPTH) ? ref_mem[addr] : 32'h0;
    if (addr >= DEPTH) ref_err = 1'b1;
    else if (we) ref_mem[addr] = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!host_ack && n < 20);
    chk32("host_ack_latency", 32'(n), 32'd1);
    chk1("host_ack", host_ack, 1'b1);
    if (!we) chk32("host_rdata", host_rdata, exp_rd);
    chk1("host_addr_err", addr_err, ref_err);
    host_req = 1'b0;
    @(posedge clk); #1;
    chk1("host_ack_pulse", host_ack, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk32({tag, "_mem_rdata"}, mem_read_data, 32'h0);
    chk32({tag, "_host_rdata"}, host_rdata, 32'h0);
    chk1({tag, "_host_ack"}, host_ack, 1'b0);
    chk256({tag, "_digest"}, digest, 256'h0);
    chk1({tag, "_digest_valid"}, digest_valid, 1'b0);
    chk1({tag, "_addr_err"}, addr_err, 1'b0);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int a;
    int n;
    int b;
    logic [31:0] d;

    reset_n = 1'b0; eng_sel = 1'b0; mem_we = 1'b0; mem_addr = 16'h0;
    mem_write_data = 32'h0; host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0;
    host_wdata = 32'h0; out_base = 16'h0080; digest_clr = 1'b0;
    ref_base = 32'h80;
    m_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Host preload of the whole array with random words, then the first
    // message word; host writes into the digest window must not capture.
    for (int i = 0; i < DEPTH; i++) begin
      host_xact(1'b1, i, $urandom);
    end
    host_xact(1'b1, 0, 32'h61626380);
    host_xact(1'b0, 0, 32'h0);
    chk32("preload_word0", host_rdata, 32'h61626380);
    chk256("host_no_capture", digest, 256'h0);
    for (int i = 0; i < 8; i++) begin
      host_xact(1'b0, int'($urandom_range(0, DEPTH - 1)), 32'h0);
    end

    // Engine read latency and random engine reads
    eng_cycle(1'b1, 1'b0, 0, 32'h0, 1'b0);
    chk32("eng_read_word0", mem_read_data, 32'h61626380);
    eng_cycle(1'b1, 1'b0, 3, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      eng_cycle(1'b1, 1'b0, int'($urandom_range(0, DEPTH - 1)), 32'h0, 1'b0);
    end

    // Directed digest capture at 0x80..0x87
    for (int i = 0; i < DW; i++) begin
      d = 32'h11111111 * 32'(i + 1);
      eng_cycle(1'b1, 1'b1, 32'h80 + i, d, 1'b0);
      chk1("valid_step", digest_valid, (i == DW - 1));
    end
    chk256("digest_directed", digest,
           256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888);
    eng_cycle(1'b1, 1'b0, 16, 32'h0, 1'b1);
    chk1("valid_after_clr", digest_valid, 1'b0);
    chk256("digest_kept_after_clr", digest,
           256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888);

    // Randomized capture rounds: random window, writes around its edges,
    // rewrites, idle cycles and occasional clears (some same-cycle).
    for (int r = 0; r < 4; r++) begin
      b = int'($urandom_range(1, DEPTH - DW - 1));
      set_base(b);
      eng_cycle(1'b1, 1'b0, b, 32'h0, 1'b1);
      for (int i = 0; i < 30; i++) begin
        a = b - 1 + int'($urandom_range(0, DW + 1));
        eng_cycle(1'b1, ($urandom_range(0, 3) != 0), a, $urandom,
                  ($urandom_range(0, 11) == 0));
      end
      // Finish the window so every round also sees a valid rise
      for (int k = 0; k < DW; k++) begin
        eng_cycle(1'b1, 1'b1, b + k, $urandom, 1'b0);
      end
      chk1("round_valid", digest_valid, 1'b1);
    end

    // Engine writes with eng_sel=0 are ignored (memory and digest)
    eng_cycle(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0);
    eng_cycle(1'b0, 1'b1, ref_base, 32'hBADC0DE5, 1'b0);
    eng_cycle(1'b1, 1'b0, 5, 32'h0, 1'b0);

    // Arbitration: host read held off while the engine owns the port
    a = int'($urandom_range(0, DEPTH - 1));
    @(negedge clk);
    eng_sel = 1'b1; mem_we = 1'b0; digest_clr = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'(a);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk1("arb_no_ack", host_ack, 1'b0);
    end
    @(negedge clk);
    eng_sel = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!host_ack && n < 20);
    chk32("arb_ack_latency", 32'(n), 32'd1);
    chk32("arb_rdata", host_rdata, ref_mem[a]);
    eng_sel  = 1'b1;
    host_req = 1'b0;
    #1;
    chk1("arb_ack_held", host_ack, 1'b1);
    @(posedge clk); #1;
    chk1("arb_ack_pulse", host_ack, 1'b0);

    // Boundaries
    chk1("err_before_oob", addr_err, 1'b0);
    eng_cycle(1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 1'b0);
    chk1("oob_err", addr_err, 1'b1);
    chk32("oob_rdata", mem_read_data, 32'h0);
    eng_cycle(1'b1, 1'b0, 0, 32'h0, 1'b0);
    host_xact(1'b0, 32'hFF, 32'h0);

    // Reset after 4 of 8 digest writes
    set_base(32'h80);
    eng_cycle(1'b1, 1'b0, 0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      eng_cycle(1'b1, 1'b1, 32'h80 + i, $urandom, 1'b0);
    end
    @(negedge clk); #2;
    reset_n = 1'b0; mem_we = 1'b0; eng_sel = 1'b0;
    #1;
    m_reset();
    chk_all_zero("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 4; i < 8; i++) begin
      eng_cycle(1'b1, 1'b1, 32'h80 + i, $urandom, 1'b0);
    end
    chk1("partial_discarded", digest_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      eng_cycle(1'b1, 1'b1, 32'h80 + i, $urandom, 1'b0);
    end
    chk1("fresh_valid", digest_valid, 1'b1);

    // Reset during H_ACK
    @(negedge clk);
    eng_sel = 1'b0; mem_we = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd10;
    @(posedge clk); #1;
    chk1("hack_before_reset", host_ack, 1'b1);
    reset_n  = 1'b0;
    host_req = 1'b0;
    #1;
    m_reset();
    chk_all_zero("hack_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk1("no_ack_after_reset", host_ack, 1'b0);
    end

    // Array survives reset; host out-of-range access
    host_xact(1'b0, 10, 32'h0);
    host_xact(1'b0, 32'h100, 32'h0);
    chk32("host_oob_rdata", host_rdata, 32'h0);
    chk1("host_oob_err", addr_err, 1'b1);
    host_xact(1'b1, 32'h100, 32'h12345678);
    host_xact(1'b0, 0, 32'h0);
    host_xact(1'b0, 32'hFF, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha_mem_responder.md
Name: sha_mem_responder

Overview:
- Word-addressed memory responder serving the bus side of the SHA-256 engine's memory master port: `mem_we`, `mem_addr`, `mem_write_data` in; `mem_read_data` out.
- Also provides a host port so a testbench or CPU can preload message words and read results.
- Captures the 8-word digest the engine writes to a configurable output window and flags it complete.
- Sits between the hash engine and system memory/host in the bitcoin_hash subsystem.

Parameters:
- DEPTH, 256, number of 32-bit words stored (addresses 0..DEPTH-1).
- DIGEST_WORDS, 8, number of words in the captured digest window.

Ports:
- clk  in  1  clock; the engine's mem_clk is the same clock.
- reset_n  in  1  asynchronous active-low reset.
- eng_sel  in  1  1 = engine owns the write port; 0 = host owns it.
- mem_we  in  1  engine write enable.
- mem_addr  in  16  engine word address.
- mem_write_data  in  32  engine write data.
- mem_read_data  out  32  engine read data (registered).
- host_req  in  1  host request, held until host_ack.
- host_we  in  1  host write (1) / read (0), valid with host_req.
- host_addr  in  16  host word address.
- host_wdata  in  32  host write data.
- host_rdata  out  32  host read data, valid while host_ack=1.
- host_ack  out  1  one-cycle completion pulse.
- out_base  in  16  first address of the digest window; static while eng_sel=1.
- digest_clr  in  1  clears digest_valid and the capture mask.
- digest  out  256  captured digest; word k at bits [255-32k -: 32].
- digest_valid  out  1  all DIGEST_WORDS words captured.
- addr_err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (asynchronous): all registered outputs go to 0: mem_read_data, host_rdata, host_ack, digest, digest_valid, addr_err. The capture mask clears and the host FSM goes to H_IDLE. Array contents are not reset.
- Storage: DEPTH x 32 array with two read ports (engine, host) and one write port.
- Engine read port, serviced every cycle regardless of eng_sel:
  - mem_read_data <= array[mem_addr] at each posedge, i.e. 1-cycle latency. An address presented in cycle N gives data in cycle N+1.
  - Read-during-write to the same address returns the old data.
  - mem_addr >= DEPTH: returns 32'h0 and sets addr_err.
- Engine write, when eng_sel=1 and mem_we=1 at a posedge:
  - array[mem_addr] <= mem_write_data.
  - mem_addr >= DEPTH: write dropped, addr_err set.
  - When eng_sel=0, engine writes are ignored with no error.
- Digest capture, on an accepted engine write with out_base <= mem_addr < out_base+DIGEST_WORDS:
  - k = mem_addr - out_base (16-bit unsigned; no wrap past 0xFFFF, so windows crossing 0xFFFF only capture the in-range part).
  - digest word k <= data and mask[k] <= 1. A rewrite of word k overwrites the data; the mask stays set.
  - digest_valid is registered: it rises the cycle after the mask becomes all-ones and holds until digest_clr or reset.
  - digest_clr and a capture write in the same cycle: clear wins for mask and valid. The memory write still lands. The digest data register is updated but not flagged.
  - digest_clr does not zero digest data.
- Host FSM:
  - H_IDLE: if host_req && !eng_sel, perform the access at this edge and go to H_ACK.
    - Write: array[host_addr] <= host_wdata.
    - Read: host_rdata <= array[host_addr].
    - host_addr >= DEPTH: write dropped / read returns 0, addr_err set, still acked.
    - If host_req && eng_sel, remain in H_IDLE (wait); no ack.
  - H_ACK: host_ack=1 for exactly one cycle with host_rdata valid, then H_IDLE. Latency is request-sample to ack = 1 cycle.
    - eng_sel rising during H_ACK does not cancel the ack; the access already completed.
    - A host still asserting host_req in the cycle after the ack starts a new transaction.
- Host writes are never captured into digest.
- addr_err: sticky; cleared only by reset.
- Reset mid-transaction: no ack is issued afterwards, and any partial capture is discarded.

Test Plan:
- Host preload: with eng_sel=0, write 0x61626380 to addr 0 → host_ack 1 cycle after req sampled. A host read of addr 0 then returns 0x61626380 with host_ack.
- Engine read latency: eng_sel=1, mem_addr=0 in cycle N → mem_read_data=0x61626380 in cycle N+1. Setting mem_addr=3 then gives word 3 one cycle later.
- Digest capture: out_base=0x80; engine writes 0x11111111..0x88888888 to 0x80..0x87 on consecutive cycles.
  - Expect digest_valid=0 through the 8th write and =1 the following cycle.
  - Expect digest=0x11111111_22222222_..._88888888.
  - digest_clr → digest_valid=0 next cycle.
- Arbitration: host_req read with eng_sel=1 for 5 cycles → no host_ack. Dropping eng_sel → host_ack exactly 1 cycle later with correct data.
- Boundaries, with DEPTH=256:
  - Engine write to 0x0100 → array unchanged, addr_err=1 next cycle.
  - Read of 0x0100 → mem_read_data=0.
  - Host read of 0x00FF returns last-word data.
- Reset mid-operation: assert reset_n=0 after 4 of 8 digest writes and during H_ACK. Expect all outputs 0 and mask cleared; after release, 8 fresh writes are needed for digest_valid.
